// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter and instruction-fetch stage of the 16-bit datapath.
// Keeps the fetch PC and issues one-word fetches to instruction memory over a
// req/ack handshake. Each returned word is registered together with its address
// and address+1 for the decode stage. If a fetch completes while decode is
// stalled, a one-entry skid buffer holds the word until decode can take it.
//
// Parameters
//   WIDTH          datapath / address width
//   RESET_PC       first fetch address after reset
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          decode cannot accept a new instruction (IR holds)
//   branch_taken   single-cycle redirect request
//   branch_target  redirect address from the branch-target adder
//   imem_req       fetch request (decoded from the state register)
//   imem_addr      fetch address, registered
//   imem_ack       fetch complete; imem_data valid this cycle
//   imem_data      fetched instruction word
//   instr          instruction register
//   instr_valid    instr holds a live instruction
//   pc_out         address of instr
//   pc_plus1       pc_out + 1, registered, base operand of the branch adder
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_data,
   output logic [WIDTH-1:0] instr,
   output logic             instr_valid,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus1
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fetchState_t;

   // Address increment wraps modulo 2^WIDTH; there is deliberately no carry out.
   function automatic logic [WIDTH-1:0] incrWrap(input logic [WIDTH-1:0] a);
      return a + ONE;
   endfunction

   fetchState_t      state,      stateNxt;
   logic [WIDTH-1:0] pcReg,      pcNxt;
   logic [WIDTH-1:0] fetchAddr,  fetchAddrNxt;
   logic [WIDTH-1:0] irData,     irDataNxt;
   logic [WIDTH-1:0] irPc,       irPcNxt;
   logic [WIDTH-1:0] irPcPlus1,  irPcPlus1Nxt;
   logic             irValid,    irValidNxt;
   logic [WIDTH-1:0] skidData,   skidDataNxt;
   logic [WIDTH-1:0] skidPc,     skidPcNxt;
   logic             skidValid,  skidValidNxt;
   logic             reqActive;
   logic             ackSeen;

   // imem_req is the only output not taken straight from a flop.
   assign reqActive = (state == REQ) || (state == DROP);
   // An ack while no request is outstanding is meaningless and ignored.
   assign ackSeen   = imem_ack & reqActive;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pcReg     <= RESET_PC;
         fetchAddr <= '0;
         irData    <= '0;
         irPc      <= '0;
         irPcPlus1 <= ONE;
         irValid   <= 1'b0;
         skidData  <= '0;
         skidPc    <= '0;
         skidValid <= 1'b0;
      end else begin
         state     <= stateNxt;
         pcReg     <= pcNxt;
         fetchAddr <= fetchAddrNxt;
         irData    <= irDataNxt;
         irPc      <= irPcNxt;
         irPcPlus1 <= irPcPlus1Nxt;
         irValid   <= irValidNxt;
         skidData  <= skidDataNxt;
         skidPc    <= skidPcNxt;
         skidValid <= skidValidNxt;
      end
   end

   always_comb begin
      stateNxt     = state;
      pcNxt        = pcReg;
      fetchAddrNxt = fetchAddr;
      irDataNxt    = irData;
      irPcNxt      = irPc;
      irPcPlus1Nxt = irPcPlus1;
      irValidNxt   = irValid;
      skidDataNxt  = skidData;
      skidPcNxt    = skidPc;
      skidValidNxt = skidValid;

      if (branch_taken) begin
         // Redirect wins over stall and ack: anything in flight or parked is stale.
         pcNxt        = branch_target;
         irValidNxt   = 1'b0;
         skidValidNxt = 1'b0;
         unique case (state)
            IDLE:    stateNxt = IDLE;
            // If the fetch completed this cycle nothing is left outstanding;
            // otherwise its response must still be absorbed in DROP.
            REQ:     stateNxt = ackSeen ? IDLE : DROP;
            DROP:    stateNxt = DROP;
            HOLD:    stateNxt = IDLE;
            default: stateNxt = IDLE;
         endcase
      end else begin
         unique case (state)
            IDLE: begin
               if (!stall) begin
                  fetchAddrNxt = pcReg;
                  stateNxt     = REQ;
               end
            end

            REQ: begin
               if (ackSeen) begin
                  pcNxt = incrWrap(fetchAddr);
                  if (!stall) begin
                     // Hand the word to decode and start the next fetch
                     // immediately for one-per-cycle throughput.
                     irDataNxt    = imem_data;
                     irPcNxt      = fetchAddr;
                     irPcPlus1Nxt = incrWrap(fetchAddr);
                     irValidNxt   = 1'b1;
                     fetchAddrNxt = incrWrap(fetchAddr);
                  end else begin
                     skidDataNxt  = imem_data;
                     skidPcNxt    = fetchAddr;
                     skidValidNxt = 1'b1;
                     stateNxt     = HOLD;
                  end
               end else if (!stall) begin
                  // Decode consumed the previous word; nothing new yet.
                  irValidNxt = 1'b0;
               end
            end

            HOLD: begin
               if (!stall) begin
                  irDataNxt    = skidData;
                  irPcNxt      = skidPc;
                  irPcPlus1Nxt = incrWrap(skidPc);
                  irValidNxt   = 1'b1;
                  skidValidNxt = 1'b0;
                  fetchAddrNxt = pcReg;
                  stateNxt     = REQ;
               end
            end

            DROP: begin
               irValidNxt = 1'b0;
               if (ackSeen) begin
                  stateNxt = IDLE;
               end
            end

            default: stateNxt = IDLE;
         endcase
      end
   end

   assign imem_req    = reqActive;
   assign imem_addr   = fetchAddr;
   assign instr       = irData;
   assign instr_valid = irValid;
   assign pc_out      = irPc;
   assign pc_plus1    = irPcPlus1;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Drives two pc_fetch_unit instances (RESET_PC 16'h0000 and 16'hFFFE) with the
// same control stimulus. Each instance's instruction memory answers with
// addr ^ 16'hA5A5. A behavioural model tracks, per instance, whether a fetch is
// outstanding, whether it is being squashed, and whether a word is parked, and
// predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        brTaken = 1'b0;
   logic [15:0] brTarget = '0;
   logic        imemAck = 1'b0;

   logic        imemReq    [2];
   logic [15:0] imemAddr   [2];
   logic [15:0] imemData   [2];
   logic [15:0] instr      [2];
   logic        instrValid [2];
   logic [15:0] pcOut      [2];
   logic [15:0] pcPlus1    [2];

   int nAsserts = 0;
   int nFails   = 0;

   always #5 clk = ~clk;

   assign imemData[0] = imemAddr[0] ^ 16'hA5A5;
   assign imemData[1] = imemAddr[1] ^ 16'hA5A5;

   pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut0 (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .branch_taken(brTaken), .branch_target(brTarget),
      .imem_req(imemReq[0]), .imem_addr(imemAddr[0]),
      .imem_ack(imemAck), .imem_data(imemData[0]),
      .instr(instr[0]), .instr_valid(instrValid[0]),
      .pc_out(pcOut[0]), .pc_plus1(pcPlus1[0])
   );

   pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'hFFFE)) dut1 (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .branch_taken(brTaken), .branch_target(brTarget),
      .imem_req(imemReq[1]), .imem_addr(imemAddr[1]),
      .imem_ack(imemAck), .imem_data(imemData[1]),
      .instr(instr[1]), .instr_valid(instrValid[1]),
      .pc_out(pcOut[1]), .pc_plus1(pcPlus1[1])
   );

   // ---------------- behavioural model ----------------
   logic [15:0] rstPc [2] = '{16'h0000, 16'hFFFE};
   logic [15:0] mPc    [2];
   logic [15:0] mAddr  [2];
   logic [15:0] mInstr [2];
   logic [15:0] mPcOut [2];
   logic [15:0] mSkD   [2];
   logic [15:0] mSkP   [2];
   bit          mFetching [2];   // a request is on the bus
   bit          mSquash   [2];   // the request on the bus is to be thrown away
   bit          mParked   [2];   // a word waits in the skid buffer
   bit          mValid    [2];

   task automatic modelReset(input int i);
      mPc[i] = rstPc[i]; mAddr[i] = '0; mInstr[i] = '0; mPcOut[i] = '0;
      mSkD[i] = '0; mSkP[i] = '0;
      mFetching[i] = 0; mSquash[i] = 0; mParked[i] = 0; mValid[i] = 0;
   endtask

   task automatic modelStep(input int i);
      bit ackEff;
      if (!rst_n) begin
         modelReset(i);
         return;
      end
      ackEff = imemAck && mFetching[i];
      if (brTaken) begin
         mPc[i] = brTarget; mValid[i] = 0; mParked[i] = 0;
         if (mFetching[i] && !mSquash[i]) begin
            if (ackEff) mFetching[i] = 0;
            else        mSquash[i] = 1;
         end else if (!mFetching[i]) begin
            mFetching[i] = 0;
         end
      end else if (mParked[i]) begin
         if (!stall) begin
            mInstr[i] = mSkD[i]; mPcOut[i] = mSkP[i]; mValid[i] = 1;
            mParked[i] = 0; mAddr[i] = mPc[i]; mFetching[i] = 1; mSquash[i] = 0;
         end
      end else if (!mFetching[i]) begin
         if (!stall) begin
            mAddr[i] = mPc[i]; mFetching[i] = 1; mSquash[i] = 0;
         end
      end else if (mSquash[i]) begin
         mValid[i] = 0;
         if (ackEff) begin
            mFetching[i] = 0; mSquash[i] = 0;
         end
      end else begin
         if (ackEff) begin
            mPc[i] = mAddr[i] + 16'd1;
            if (!stall) begin
               mInstr[i] = mAddr[i] ^ 16'hA5A5; mPcOut[i] = mAddr[i]; mValid[i] = 1;
               mAddr[i] = mAddr[i] + 16'd1;
            end else begin
               mSkD[i] = mAddr[i] ^ 16'hA5A5; mSkP[i] = mAddr[i];
               mParked[i] = 1; mFetching[i] = 0;
            end
         end else if (!stall) begin
            mValid[i] = 0;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input int inst, input logic [15:0] obs,
                      input logic [15:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
      end
   endtask

   task automatic checkAll();
      for (int i = 0; i < 2; i++) begin
         logic [15:0] expPlus1;
         expPlus1 = mPcOut[i] + 16'd1;
         chk("imem_req",    i, {15'd0, imemReq[i]},    {15'd0, mFetching[i]});
         chk("imem_addr",   i, imemAddr[i],            mAddr[i]);
         chk("instr",       i, instr[i],               mInstr[i]);
         chk("instr_valid", i, {15'd0, instrValid[i]}, {15'd0, mValid[i]});
         chk("pc_out",      i, pcOut[i],               mPcOut[i]);
         chk("pc_plus1",    i, pcPlus1[i],             expPlus1);
      end
   endtask

   task automatic checkResetValues();
      for (int i = 0; i < 2; i++) begin
         chk("rst_imem_req",    i, {15'd0, imemReq[i]},    16'h0000);
         chk("rst_imem_addr",   i, imemAddr[i],            16'h0000);
         chk("rst_instr",       i, instr[i],               16'h0000);
         chk("rst_instr_valid", i, {15'd0, instrValid[i]}, 16'h0000);
         chk("rst_pc_out",      i, pcOut[i],               16'h0000);
         chk("rst_pc_plus1",    i, pcPlus1[i],             16'h0001);
      end
   endtask

   // Called at a falling edge: apply inputs, advance the model, check after the edge.
   task automatic step(input logic s, input logic a, input logic b, input logic [15:0] t);
      stall = s; imemAck = a; brTaken = b; brTarget = t;
      modelStep(0);
      modelStep(1);
      @(posedge clk);
      @(negedge clk);
      checkAll();
   endtask

   // Continuous-ack fetching until instance 0 is requesting address a.
   task automatic runUntil(input logic [15:0] a, input int budget);
      int n;
      bit reached;
      n = 0;
      while (!(mFetching[0] && !mSquash[0] && mAddr[0] == a) && n < budget) begin
         step(1'b0, 1'b1, 1'b0, 16'h0000);
         n++;
      end
      reached = mFetching[0] && !mSquash[0] && mAddr[0] == a;
      chk("reach_addr", 0, {15'd0, reached}, 16'h0001);
   endtask

   // Reset asserted at a falling edge takes effect without a clock edge.
   task automatic applyReset();
      rst_n = 1'b0;
      #1;
      checkResetValues();
      modelReset(0);
      modelReset(1);
      @(negedge clk);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      rst_n = 1'b1;
   endtask

   initial begin
      modelReset(0);
      modelReset(1);
      @(negedge clk);
      @(negedge clk);
      checkResetValues();
      rst_n = 1'b1;

      // Streaming fetch, then a 3-cycle ack gap at address 2.
      runUntil(16'h0002, 20);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0000);

      // Stall arrives with the ack of address 5: word parks, bus goes idle.
      runUntil(16'h0005, 20);
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("hold_release_pc_out", 0, pcOut[0], 16'h0005);
      chk("hold_release_addr",   0, imemAddr[0], 16'h0006);

      // Branch while the fetch of address 7 is outstanding.
      runUntil(16'h0007, 20);
      step(1'b0, 1'b0, 1'b1, 16'h0040);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      chk("drop_no_valid", 0, {15'd0, instrValid[0]}, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("branch_target_addr", 0, imemAddr[0], 16'h0040);

      // Branch while a word sits in the skid buffer and decode is stalled.
      runUntil(16'h0042, 20);
      step(1'b1, 1'b1, 1'b0, 16'h0000);
      step(1'b1, 1'b0, 1'b1, 16'h0100);
      chk("hold_branch_valid", 0, {15'd0, instrValid[0]}, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      chk("hold_branch_addr", 0, imemAddr[0], 16'h0100);

      // Randomised traffic.
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0, 16'($urandom));
      end

      // Fresh reset, then wraparound on the RESET_PC=16'hFFFE instance.
      @(negedge clk);
      applyReset();
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      chk("wrap_first_addr", 1, imemAddr[1], 16'hFFFE);
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      chk("wrap_pc_out",   1, pcOut[1],    16'hFFFF);
      chk("wrap_pc_plus1", 1, pcPlus1[1],  16'h0000);
      chk("wrap_addr",     1, imemAddr[1], 16'h0000);

      // Reset in the middle of an outstanding request.
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      applyReset();
      step(1'b0, 1'b1, 1'b0, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
